// File: rtl/display_scan_driver_pkg.sv
// display_scan_driver_pkg: shared FSM encoding and 16-bit shift word layout.
package display_scan_driver_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH, DONE} state_t;
  localparam int ANODE_MSB = 15;
  localparam int SEG_MSB = 7;
  localparam int ANODE_W = ANODE_MSB - SEG_MSB;
endpackage

// File: rtl/display_scan_driver_serial_shift_out.sv
// serial_shift_out: word capture, MSB-first bit sequencing and serial-clock divider.
module serial_shift_out
  import display_scan_driver_pkg::*;
#(
  parameter int SCLK_DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  state_t           state,
  input  state_t           nxt,
  input  logic [ANODE_MSB:0] word,
  output logic             data,
  output logic             sclk,
  output logic             latch,
  output logic             div_zero,
  output logic             bit_zero
);
  localparam int DW = $clog2(SCLK_DIV + 1);
  localparam logic [DW-1:0] RELOAD = DW'(SCLK_DIV - 1);
  logic [DW-1:0] div;
  logic [ANODE_MSB:0] sr;
  logic [3:0] bitcnt;
  assign div_zero = div == '0;
  assign bit_zero = bitcnt == '0;
  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      div <= '0;
      sr <= '0;
      bitcnt <= '0;
      data <= 1'b0;
      sclk <= 1'b0;
      latch <= 1'b0;
    end else begin
      div <= (nxt != state) ? RELOAD : (div_zero ? div : div - DW'(1));
      sclk <= nxt == SHIFT_HI;
      latch <= nxt == LATCH;
      if (state == LOAD) begin
        sr <= word;
        bitcnt <= 4'd15;
        data <= word[ANODE_MSB];
      end else if (state == SHIFT_HI && nxt == SHIFT_LO) begin
        bitcnt <= bitcnt - 4'd1;
        data <= sr[bitcnt - 4'd1];
      end
    end
endmodule

// File: rtl/display_scan_driver.sv
// display_scan_driver: per-frame digit sequencer feeding an anode+segment word to a serial shifter.
module display_scan_driver
  import display_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int SCLK_DIV = 1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_refresh_stb,
  output logic [3:0] o_seg_select,
  input  logic [7:0] i_7seg,
  output logic       o_serial_data,
  output logic       o_serial_clk,
  output logic       o_serial_latch,
  output logic       o_busy,
  output logic       o_frame_done
);
  state_t state, nxt;
  logic div_zero, bit_zero, last_digit;
  logic [ANODE_W-1:0] anode;
  logic [ANODE_MSB:0] word;
  assign anode = ANODE_W'(1) << o_seg_select;
  assign word = {anode, i_7seg[SEG_MSB:0]};
  assign last_digit = o_seg_select == 4'(NUM_DIGITS - 1);
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = i_refresh_stb ? LOAD : IDLE;
      LOAD:     nxt = SHIFT_LO;
      SHIFT_LO: nxt = div_zero ? SHIFT_HI : SHIFT_LO;
      SHIFT_HI: nxt = !div_zero ? SHIFT_HI : bit_zero ? LATCH : SHIFT_LO;
      LATCH:    nxt = !div_zero ? LATCH : last_digit ? DONE : LOAD;
      DONE:     nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      state <= IDLE;
      o_seg_select <= '0;
      o_busy <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      state <= nxt;
      o_busy <= nxt != IDLE && nxt != DONE;
      o_frame_done <= nxt == DONE;
      if (state == IDLE && nxt == LOAD) o_seg_select <= '0;
      else if (state == LATCH && nxt == LOAD) o_seg_select <= o_seg_select + 4'd1;
    end
  serial_shift_out #(.SCLK_DIV(SCLK_DIV)) u_shift (
    .clk(i_clk),
    .rst(i_reset),
    .state(state),
    .nxt(nxt),
    .word(word),
    .data(o_serial_data),
    .sclk(o_serial_clk),
    .latch(o_serial_latch),
    .div_zero(div_zero),
    .bit_zero(bit_zero)
  );
endmodule

// File: tb/tb_display_scan_driver.sv
// tb_display_scan_driver: directed and random frames checked against a word-level display model.
module tb_display_scan_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stb_a = 1'b0, stb_b = 1'b0;
  logic [3:0] sel_a, sel_b;
  logic [7:0] seg_a, seg_b;
  logic data_a, sclk_a, latch_a, busy_a, done_a;
  logic data_b, sclk_b, latch_b, busy_b, done_b;
  logic [7:0] pat_a [16];
  logic [7:0] pat_b [16];
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  assign seg_a = pat_a[sel_a];
  assign seg_b = pat_b[sel_b];
  display_scan_driver dut_a (
    .i_clk(clk), .i_reset(rst), .i_refresh_stb(stb_a), .o_seg_select(sel_a), .i_7seg(seg_a),
    .o_serial_data(data_a), .o_serial_clk(sclk_a), .o_serial_latch(latch_a),
    .o_busy(busy_a), .o_frame_done(done_a)
  );
  display_scan_driver #(.NUM_DIGITS(6), .SCLK_DIV(3)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_refresh_stb(stb_b), .o_seg_select(sel_b), .i_7seg(seg_b),
    .o_serial_data(data_b), .o_serial_clk(sclk_b), .o_serial_latch(latch_b),
    .o_busy(busy_b), .o_frame_done(done_b)
  );
  // Shift-register model for instance A: words captured at each latch rising edge.
  logic p_sclk_a = 0, p_latch_a = 0, p_busy_a = 0, p_done_a = 0;
  logic [15:0] sh_a = 0;
  logic [15:0] words_a [$];
  int cyc = 0, rises_a = 0, lat_cnt_a = 0, done_cnt_a = 0, busy_at_a = 0, frame_len_a = 0;
  always @(negedge clk) begin
    cyc++;
    if (sclk_a && !p_sclk_a) begin sh_a = {sh_a[14:0], data_a}; rises_a++; end
    if (latch_a && !p_latch_a) begin words_a.push_back(sh_a); lat_cnt_a++; end
    if (busy_a && !p_busy_a) busy_at_a = cyc;
    if (done_a && !p_done_a) begin done_cnt_a++; frame_len_a = cyc - busy_at_a; end
    p_sclk_a = sclk_a; p_latch_a = latch_a; p_busy_a = busy_a; p_done_a = done_a;
  end
  // Instance B additionally measures phase widths in cycles.
  logic p_sclk_b = 0, p_latch_b = 0, p_busy_b = 0, p_done_b = 0;
  logic [15:0] sh_b = 0;
  logic [15:0] words_b [$];
  int ints_b [$];
  int hi_len = 0, lo_len = 0, lat_len = 0, hi3 = 0, hi_other = 0, lo3 = 0, lo7 = 0, lat3 = 0;
  int last_lat = -1, done_cnt_b = 0, busy_at_b = 0, frame_len_b = 0;
  always @(negedge clk) begin
    if (sclk_b && !p_sclk_b) begin
      sh_b = {sh_b[14:0], data_b};
      if (lo_len == 3) lo3++; else if (lo_len == 7) lo7++;
      lo_len = 0;
    end
    if (!sclk_b && p_sclk_b) begin
      if (hi_len == 3) hi3++; else hi_other++;
      hi_len = 0;
    end
    if (sclk_b) hi_len++; else lo_len++;
    if (!latch_b && p_latch_b) begin if (lat_len == 3) lat3++; lat_len = 0; end
    if (latch_b) lat_len++;
    if (latch_b && !p_latch_b) begin
      if (last_lat >= 0) ints_b.push_back(cyc - last_lat);
      last_lat = cyc;
      words_b.push_back(sh_b);
    end
    if (busy_b && !p_busy_b) busy_at_b = cyc;
    if (done_b && !p_done_b) begin done_cnt_b++; frame_len_b = cyc - busy_at_b; end
    p_sclk_b = sclk_b; p_latch_b = latch_b; p_busy_b = busy_b; p_done_b = done_b;
  end
  function automatic logic [6:0] enc(input int v);
    case (v)
      0: enc = 7'h3F; 1: enc = 7'h06; 2: enc = 7'h5B; 3: enc = 7'h4F; 4: enc = 7'h66;
      5: enc = 7'h6D; 6: enc = 7'h7D; 7: enc = 7'h07; 8: enc = 7'h7F; default: enc = 7'h6F;
    endcase
  endfunction
  function automatic int dec(input logic [7:0] b);
    dec = 15;
    for (int v = 0; v < 10; v++) if (enc(v) == b[6:0]) dec = v;
  endfunction
  function automatic logic [15:0] exp_word(input int d, input logic [7:0] s);
    exp_word = (16'h0100 << d) | {8'h00, s};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic pulse_a;
    @(negedge clk); stb_a = 1'b1;
    @(negedge clk); stb_a = 1'b0;
  endtask
  task automatic run_a(input int budget);
    int d0;
    d0 = done_cnt_a;
    for (int i = 0; i < budget && done_cnt_a == d0; i++) @(negedge clk);
  endtask
  task automatic check_words_a(input string tag);
    logic [15:0] w;
    chk({tag, "_count"}, words_a.size(), 6);
    for (int d = 0; d < 6; d++) begin
      w = (words_a.size() > d) ? words_a[d] : 16'hxxxx;
      chk($sformatf("%s_word%0d", tag, d), w, exp_word(d, pat_a[d]));
    end
  endtask
  task automatic frame_a(input string tag);
    int d0;
    d0 = done_cnt_a;
    words_a.delete();
    pulse_a;
    run_a(2000);
    @(negedge clk);
    chk({tag, "_done"}, done_cnt_a - d0, 1);
    chk({tag, "_len"}, frame_len_a, 204);
    chk({tag, "_busy"}, busy_a, 0);
    check_words_a(tag);
  endtask
  initial begin
    int nz, d0, l0;
    int dig [6];
    logic [15:0] w;
    dig = '{1, 2, 3, 0, 5, 9};
    for (int i = 0; i < 16; i++) begin pat_a[i] = 8'h00; pat_b[i] = 8'h00; end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_a", {sel_a, data_a, sclk_a, latch_a, busy_a, done_a}, 0);
    chk("reset_b", {sel_b, data_b, sclk_b, latch_b, busy_b, done_b}, 0);
    nz = 0;
    repeat (100) begin
      @(negedge clk);
      nz |= int'(|{sel_a, data_a, sclk_a, latch_a, busy_a, done_a, sel_b, data_b, sclk_b, latch_b, busy_b, done_b});
    end
    chk("idle100", nz, 0);
    for (int i = 0; i < 16; i++) pat_a[i] = 8'h3F;
    frame_a("f3f");
    w = words_a.size() > 0 ? words_a[0] : 16'hxxxx;
    chk("f3f_first", w, 16'h013F);
    w = words_a.size() > 5 ? words_a[5] : 16'hxxxx;
    chk("f3f_last", w, 16'h203F);
    for (int i = 0; i < 6; i++) pat_a[i] = {(i == 1 || i == 3), enc(dig[i])};
    frame_a("clock");
    for (int i = 0; i < 6; i++) begin
      w = words_a.size() > i ? words_a[i] : 16'h0000;
      chk($sformatf("bcd%0d", i), dec(w[7:0]), dig[i]);
    end
    repeat (3) begin
      for (int i = 0; i < 16; i++) pat_a[i] = 8'($urandom);
      frame_a("rand");
    end
    for (int i = 0; i < 16; i++) pat_a[i] = 8'($urandom);
    words_a.delete();
    d0 = done_cnt_a;
    l0 = lat_cnt_a;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk); stb_a = 1'b1;
      @(negedge clk); stb_a = 1'b0;
      repeat (8) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    chk("restb_latches", lat_cnt_a - l0, 6);
    chk("restb_done", done_cnt_a - d0, 1);
    check_words_a("restb");
    d0 = done_cnt_a;
    l0 = lat_cnt_a;
    pulse_a;
    repeat (204) @(negedge clk);
    chk("done_cycle", done_a, 1);
    chk("done_busy", busy_a, 0);
    stb_a = 1'b1;
    @(negedge clk); stb_a = 1'b0;
    repeat (250) @(negedge clk);
    chk("donestb_done", done_cnt_a - d0, 1);
    chk("donestb_latches", lat_cnt_a - l0, 6);
    chk("donestb_busy", busy_a, 0);
    for (int i = 0; i < 16; i++) pat_b[i] = 8'($urandom);
    words_b.delete();
    @(negedge clk); stb_b = 1'b1;
    @(negedge clk); stb_b = 1'b0;
    for (int i = 0; i < 3000 && done_cnt_b == 0; i++) @(negedge clk);
    @(negedge clk);
    chk("b_done", done_cnt_b, 1);
    chk("b_len", frame_len_b, 600);
    chk("b_hi3", hi3, 96);
    chk("b_hi_other", hi_other, 0);
    chk("b_lo3", lo3, 90);
    chk("b_lo7", lo7, 5);
    chk("b_latch3", lat3, 6);
    chk("b_ints", ints_b.size(), 5);
    foreach (ints_b[i]) chk($sformatf("b_digit_time%0d", i), ints_b[i], 100);
    chk("b_count", words_b.size(), 6);
    for (int d = 0; d < 6; d++) begin
      w = words_b.size() > d ? words_b[d] : 16'hxxxx;
      chk($sformatf("b_word%0d", d), w, exp_word(d, pat_b[d]));
    end
    for (int i = 0; i < 16; i++) pat_a[i] = 8'($urandom);
    words_a.delete();
    d0 = done_cnt_a;
    nz = rises_a;
    pulse_a;
    for (int i = 0; i < 1000 && rises_a - nz < 56; i++) @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("abort_outputs", {sel_a, data_a, sclk_a, latch_a, busy_a, done_a}, 0);
    l0 = lat_cnt_a;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("abort_latches", lat_cnt_a - l0, 0);
    chk("abort_words", words_a.size(), 3);
    chk("abort_done", done_cnt_a - d0, 0);
    chk("abort_idle", busy_a, 0);
    frame_a("after_rst");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/display_scan_driver.md
DISPLAY_SCAN_DRIVER -- requirements
Module: display_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 6, giving the digits scanned per frame (1..8).
REQ-002 SHALL have parameter SCLK_DIV, default 1, giving the system clocks per serial-clock half-period (>=1).
REQ-003 SHALL have port i_clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port i_reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port i_refresh_stb, input, 1, a one-cycle pulse that requests one display frame.
REQ-006 SHALL have port o_seg_select, output, 4, the digit index presented to the time-to-7-segment converter (0 = hours MSD, 5 = seconds LSD).
REQ-007 SHALL have port i_7seg, input, 8, the converter's segment pattern for o_seg_select; bit 7 is the decimal point.
REQ-008 SHALL have port o_serial_data, output, 1, shift-register data, MSB first.
REQ-009 SHALL have port o_serial_clk, output, 1, shift-register clock; external devices sample on its rising edge.
REQ-010 SHALL have port o_serial_latch, output, 1, storage-register latch pulse, active high.
REQ-011 SHALL have port o_busy, output, 1, high from frame acceptance until frame completion.
REQ-012 SHALL have port o_frame_done, output, 1, a one-cycle pulse at frame completion.

Function
REQ-013 SHALL implement states IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH and DONE.
REQ-014 In IDLE, when i_refresh_stb=1, SHALL set digit=0 and o_seg_select=0 and go to LOAD; o_busy SHALL rise on the next cycle.
REQ-015 In IDLE, when i_refresh_stb=0, SHALL hold all outputs.
REQ-016 While o_busy=1, SHALL ignore i_refresh_stb (no queuing).
REQ-017 LOAD SHALL last 1 cycle.
REQ-018 LOAD SHALL capture the 16-bit word {one-hot anode[7:0] = 1<<digit, i_7seg[7:0]} into the shift register and set bitcnt=15.
REQ-019 o_seg_select SHALL be stable for at least one full cycle before the LOAD capture edge.
REQ-020 In SHIFT_LO, o_serial_clk SHALL be 0 and o_serial_data SHALL equal word[bitcnt], for SCLK_DIV cycles.
REQ-021 SHIFT_HI SHALL drive o_serial_clk=1 for SCLK_DIV cycles, with o_serial_data unchanged.
REQ-022 After SHIFT_HI, when bitcnt>0, SHALL decrement bitcnt and return to SHIFT_LO; when bitcnt=0, SHALL go to LATCH.
REQ-023 LATCH SHALL drive o_serial_latch=1 for SCLK_DIV cycles, with o_serial_clk=0.
REQ-024 After LATCH, when digit<NUM_DIGITS-1, SHALL increment digit and o_seg_select and go to LOAD.
REQ-025 After LATCH on the last digit, SHALL go to DONE.
REQ-026 DONE SHALL pulse o_frame_done for 1 cycle, clear o_busy and return to IDLE.
REQ-027 A strobe in the DONE cycle SHALL be ignored.
REQ-028 Digit latency SHALL be 1 + 32*SCLK_DIV + SCLK_DIV cycles; with defaults, 34 cycles per digit and 204 cycles from LOAD entry to DONE.
REQ-029 The divider counter SHALL be ceil(log2(SCLK_DIV+1)) bits and SHALL reload to SCLK_DIV-1 on every state change.
REQ-030 o_serial_clk, o_serial_latch, o_serial_data and o_frame_done SHALL be registered (glitch-free).

Reset
REQ-031 Asserting i_reset SHALL immediately force state=IDLE, digit=0, o_seg_select=0, o_serial_data=0, o_serial_clk=0, o_serial_latch=0, o_busy=0, o_frame_done=0, and clear the shift register.
REQ-032 Reset mid-frame SHALL abort without generating a latch pulse.
REQ-033 After reset deassertion, the first frame SHALL start only on a new i_refresh_stb.

Structure
REQ-034 The state encoding and the 16-bit word layout constants (ANODE_MSB=15, SEG_MSB=7) SHALL be placed in a shared package.
REQ-035 The serial shifter (load, shift, bit counter, divider) SHALL be a sub-module named serial_shift_out; the digit-sequencing FSM SHALL remain in the top.

Verification
REQ-036 After reset with no strobe for 100 cycles, all outputs SHALL stay 0.
REQ-037 With i_7seg = 0x3F for every select and one strobe, the bench SHALL see 6 latch pulses, deserialized words 0x013F, 0x023F, 0x043F, 0x083F, 0x103F, 0x203F, and o_frame_done exactly 204 cycles after LOAD entry.
REQ-038 With the clock_to_7seg model at 12:30.59 driving i_7seg, the bench SHALL decode segment bytes to BCD digits 1, 2, 3, 0, 5, 9 in latch order.
REQ-039 Strobes repeated every 10 cycles during a frame SHALL not change the result: still exactly 6 latches and 1 o_frame_done.
REQ-040 With i_reset asserted during digit 3 at bit 7, the bench SHALL see all outputs 0 within the same cycle, no further latch pulses, and a clean full frame after the next strobe.
REQ-041 With SCLK_DIV=3, o_serial_clk high and low phases SHALL each be 3 cycles, the latch pulse 3 cycles, and digit time 100 cycles.
